sim_watchdog: RTL and testbench
===============================

// Module: sim_watchdog
// PURPOSE
//  Multi-channel run controller/watchdog for the verification benches. Arms on start, counts
//  cycles against a global budget, and checks that each enabled channel (pito hart, MVU
//  lane, ...) kicks within a per-channel window. Ends in PASS on done, or FAIL on timeout.
//  The bench polls the outputs and calls $finish; no delays or $finish inside this block.
// PARAMETERS
//  NUM_CH          4      number of heartbeat channels (1..32)
//  CNT_W           32     width of the global cycle counter and its output
//  GLOBAL_TIMEOUT  10000  cycles allowed from start to done; must be < 2**CNT_W
//  CH_TIMEOUT      1000   max cycles between kicks on an enabled channel; >= 2
//  FAIL_ON_CH      1      1: channel timeout -> FAIL; 0: flag only, channel re-arms, run continues
// PORTS
//  clk             in   1                 bench clock
//  rst             in   1                 synchronous, active-high reset
//  start           in   1                 pulse: arm or re-arm the run
//  done            in   1                 pulse: test finished OK
//  ch_en           in   NUM_CH            per-channel enable; disabled channel counter held at 0
//  kick            in   NUM_CH            per-channel heartbeat, 1-cycle pulses
//  active          out  1                 state == RUN
//  pass            out  1                 state == PASS
//  fail            out  1                 state == FAIL
//  global_to       out  1                 sticky: global budget exhausted
//  ch_to           out  NUM_CH            sticky per-channel timeout flags
//  first_ch        out  $clog2(NUM_CH)+1  MSB=valid; low bits = lowest-index channel to time out first
//  to_count        out  8                 saturating count of channel timeouts (at 255)
//  cycle_count     out  CNT_W             cycles spent in RUN; frozen in PASS/FAIL
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, all counters 0. Reset during any state wins over all inputs.
//  FSM states: IDLE, RUN, PASS, FAIL (registered; outputs are decoded from registered state).
//   IDLE->RUN on start. RUN->PASS on done. RUN->FAIL on global or (FAIL_ON_CH) channel timeout.
//   PASS/FAIL hold until start -> RUN. start in RUN restarts the run.
//   Every entry to RUN clears: cycle_count, channel counters, global_to, ch_to, first_ch, to_count.
//  Global: in RUN, cycle_count increments by 1 each cycle. On the edge where it would reach
//   GLOBAL_TIMEOUT, global_to sets and state goes to FAIL (cycle_count stops at GLOBAL_TIMEOUT).
//  Channel i: counter increments each RUN cycle when ch_en[i]=1 and kick[i]=0. kick[i] clears it
//   to 0. On the edge where it would reach CH_TIMEOUT (no kick), ch_to[i] sets and to_count += 1.
//   With FAIL_ON_CH=0 the counter clears to 0 and counting restarts. kick on the expiry cycle wins.
//   Toggling ch_en[i] from 0 to 1 starts from 0.
//  Latency: flags, state and counters update on the same edge as the event; outputs are visible
//   the cycle after the input is sampled.
//  Simultaneous events, in priority order:
//   rst > start > timeout (global or channel) > done. A timeout in the same cycle as done -> FAIL.
//   Several channels expiring together: all ch_to bits set, first_ch = lowest index, and
//   to_count adds the number of expiring channels (saturating).
//   first_ch is written only while its valid bit is 0.
//  kick, done and ch_en are ignored outside RUN. Counters do not wrap.
//  Invalid parameters, CH_TIMEOUT<2 or GLOBAL_TIMEOUT>=2**CNT_W, trigger $fatal at elaboration.
// TESTING (NUM_CH=4, CH_TIMEOUT=8, GLOBAL_TIMEOUT=100, FAIL_ON_CH=1 unless noted)
//  1 rst, start, ch_en=4'hF, kick all every 5 cycles, done at cycle 50
//    -> pass=1, cycle_count=50, ch_to=0, fail=0.
//  2 start, ch_en=4'h0, no done
//    -> fail=1 and global_to=1 exactly 100 cycles after start, cycle_count=100.
//  3 start, ch_en=4'b0110, kick only ch1; ch2 silent
//    -> FAIL 8 cycles after start, ch_to=4'b0100, first_ch=3'b110, to_count=1.
//  4 kick on the exact expiry cycle of ch0 -> no timeout.
//    ch0 and ch3 expire on the same cycle -> ch_to=4'b1001, first_ch=3'b100, to_count=2.
//  5 FAIL_ON_CH=0, ch0 enabled and never kicked, done at cycle 40
//    -> to_count=5, ch_to[0]=1, final state PASS, cycle_count=40.
//  6 rst pulse at cycle 30 of a run -> all outputs 0 next cycle, IDLE.
//    start in FAIL -> active=1 and flags cleared next cycle.

Source files
------------

// File: rtl/sim_watchdog.sv
// Run controller / watchdog for simulation benches: a global cycle budget plus per-channel
// heartbeat windows, ending in PASS on done or FAIL on timeout.
module sim_watchdog #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int GLOBAL_TIMEOUT = 10000,
  parameter int CH_TIMEOUT     = 1000,
  parameter int FAIL_ON_CH     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       done,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH-1:0]          kick,
  output logic                       active,
  output logic                       pass,
  output logic                       fail,
  output logic                       global_to,
  output logic [NUM_CH-1:0]          ch_to,
  output logic [$clog2(NUM_CH):0]    first_ch,
  output logic [7:0]                 to_count,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int FC_W = $clog2(NUM_CH) + 1;
  localparam int CH_W = $clog2(CH_TIMEOUT + 1);

  if (CH_TIMEOUT < 2) begin : g_bad_ch_timeout
    $fatal(1, "sim_watchdog: CH_TIMEOUT must be >= 2");
  end
  if ((GLOBAL_TIMEOUT < 1) ||
      ((CNT_W < 63) && (64'(GLOBAL_TIMEOUT) >= (64'd1 << CNT_W)))) begin : g_bad_global_timeout
    $fatal(1, "sim_watchdog: GLOBAL_TIMEOUT must be in 1 .. 2**CNT_W-1");
  end
  if ((NUM_CH < 1) || (NUM_CH > 32)) begin : g_bad_num_ch
    $fatal(1, "sim_watchdog: NUM_CH must be in 1..32");
  end

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cycle_reg, cycle_next;
  logic                global_to_reg, global_to_next;
  logic [NUM_CH-1:0]   ch_to_reg, ch_to_next;
  logic [FC_W-1:0]     first_reg, first_next;
  logic [7:0]          to_cnt_reg, to_cnt_next;
  logic [NUM_CH-1:0]   expire;
  logic                global_hit;
  logic [5:0]          n_expire;
  logic [FC_W-1:0]     low_idx;
  logic [8:0]          to_sum;

  // Per-channel heartbeat counters; a kick on the expiry cycle clears instead of expiring.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CH_W-1:0] cnt_reg;

    assign expire[gi] = (state_reg == RUN) && ch_en[gi] && !kick[gi] &&
                        (cnt_reg == CH_W'(CH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
      if (rst || start) begin
        cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        if (!ch_en[gi] || kick[gi] || expire[gi]) cnt_reg <= '0;
        else                                      cnt_reg <= cnt_reg + CH_W'(1);
      end
    end
  end

  assign global_hit = (state_reg == RUN) && (cycle_reg == CNT_W'(GLOBAL_TIMEOUT - 1));

  always_comb begin
    n_expire = '0;
    low_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      n_expire = n_expire + 6'(expire[i]);
      if (expire[i]) low_idx = FC_W'(i);
    end
    to_sum = {1'b0, to_cnt_reg} + {3'b000, n_expire};
  end

  always_comb begin
    state_next     = state_reg;
    cycle_next     = cycle_reg;
    global_to_next = global_to_reg;
    ch_to_next     = ch_to_reg;
    first_next     = first_reg;
    to_cnt_next    = to_cnt_reg;

    if (start) begin
      state_next     = RUN;
      cycle_next     = '0;
      global_to_next = 1'b0;
      ch_to_next     = '0;
      first_next     = '0;
      to_cnt_next    = '0;
    end else if (state_reg == RUN) begin
      cycle_next = cycle_reg + CNT_W'(1);
      if (global_hit) global_to_next = 1'b1;
      ch_to_next = ch_to_reg | expire;
      if ((|expire) && !first_reg[FC_W-1])
        first_next = low_idx | (FC_W'(1) << (FC_W - 1));
      to_cnt_next = to_sum[8] ? 8'hFF : to_sum[7:0];
      // Timeouts outrank a done arriving in the same cycle.
      if (global_hit || ((FAIL_ON_CH != 0) && (|expire))) state_next = FAIL;
      else if (done)                                      state_next = PASS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cycle_reg     <= '0;
      global_to_reg <= 1'b0;
      ch_to_reg     <= '0;
      first_reg     <= '0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cycle_reg     <= cycle_next;
      global_to_reg <= global_to_next;
      ch_to_reg     <= ch_to_next;
      first_reg     <= first_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  assign active      = (state_reg == RUN);
  assign pass        = (state_reg == PASS);
  assign fail        = (state_reg == FAIL);
  assign global_to   = global_to_reg;
  assign ch_to       = ch_to_reg;
  assign first_ch    = first_reg;
  assign to_count    = to_cnt_reg;
  assign cycle_count = cycle_reg;

endmodule

// File: tb/tb_sim_watchdog.sv
// Bench for sim_watchdog: two instances (channel timeout fatal / non-fatal) driven by the same
// stimulus, checked cycle by cycle against a timestamp-based reference model via a scoreboard.
module tb_sim_watchdog;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int GT  = 100;
  localparam int CT  = 8;

  typedef logic [50:0] snap_t;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, done = 1'b0;
  logic [3:0] ch_en = '0, kick = '0;

  logic active_a, pass_a, fail_a, gto_a, active_b, pass_b, fail_b, gto_b;
  logic [3:0] chto_a, chto_b;
  logic [2:0] first_a, first_b;
  logic [7:0] toc_a, toc_b;
  logic [31:0] cyc_a, cyc_b;

  always #5 clk = ~clk;

  sim_watchdog #(.NUM_CH(NCH), .CNT_W(CW), .GLOBAL_TIMEOUT(GT), .CH_TIMEOUT(CT), .FAIL_ON_CH(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .done(done), .ch_en(ch_en), .kick(kick),
    .active(active_a), .pass(pass_a), .fail(fail_a), .global_to(gto_a), .ch_to(chto_a),
    .first_ch(first_a), .to_count(toc_a), .cycle_count(cyc_a));

  sim_watchdog #(.NUM_CH(NCH), .CNT_W(CW), .GLOBAL_TIMEOUT(GT), .CH_TIMEOUT(CT), .FAIL_ON_CH(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .done(done), .ch_en(ch_en), .kick(kick),
    .active(active_b), .pass(pass_b), .fail(fail_b), .global_to(gto_b), .ch_to(chto_b),
    .first_ch(first_b), .to_count(toc_b), .cycle_count(cyc_b));

  int n_checks = 0;
  int n_fail   = 0;
  longint k    = 0;   // index of the next clock edge
  snap_t q0[$], q1[$];

  // Reference model: state 0 idle, 1 run, 2 pass, 3 fail. Windows are tracked as timestamps.
  int     m_state [2];
  longint m_start [2];
  longint m_cyc   [2];
  logic   m_gto   [2];
  logic [3:0] m_chto [2];
  logic [2:0] m_first[2];
  int     m_toc   [2];
  longint m_ref   [2][4];

  task automatic model_step(input int d, input bit fail_on_ch);
    longint c;
    logic [3:0] ex;
    int n;
    if (rst) begin
      m_state[d] = 0; m_cyc[d] = 0; m_gto[d] = 0; m_chto[d] = 0; m_first[d] = 0; m_toc[d] = 0;
    end else if (start) begin
      m_state[d] = 1; m_start[d] = k; m_cyc[d] = 0; m_gto[d] = 0;
      m_chto[d] = 0; m_first[d] = 0; m_toc[d] = 0;
      for (int i = 0; i < 4; i++) m_ref[d][i] = k;
    end else if (m_state[d] == 1) begin
      c = k - m_start[d];
      ex = '0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
        if (!ch_en[i] || kick[i]) m_ref[d][i] = k;
        else if (k - m_ref[d][i] == CT) begin
          ex[i] = 1'b1; m_ref[d][i] = k; n++;
        end
      end
      m_cyc[d] = c;
      if (c == GT) m_gto[d] = 1'b1;
      m_chto[d] |= ex;
      if (ex != 0 && !m_first[d][2])
        for (int i = 3; i >= 0; i--) if (ex[i]) m_first[d] = {1'b1, 2'(i)};
      m_toc[d] = (m_toc[d] + n > 255) ? 255 : m_toc[d] + n;
      if (c == GT || (fail_on_ch && ex != 0)) m_state[d] = 3;
      else if (done)                          m_state[d] = 2;
    end
  endtask

  function automatic snap_t model_snap(input int d);
    return {m_state[d] == 1, m_state[d] == 2, m_state[d] == 3, m_gto[d], m_chto[d],
            m_first[d], 8'(m_toc[d]), 32'(m_cyc[d])};
  endfunction

  task automatic drive(input bit r, input bit s, input bit dn, input logic [3:0] en,
                       input logic [3:0] kk);
    @(negedge clk);
    rst = r; start = s; done = dn; ch_en = en; kick = kk;
    k++;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    q0.push_back(model_snap(0));
    q1.push_back(model_snap(1));
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare against the oldest queued expectation.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = {active_a, pass_a, fail_a, gto_a, chto_a, first_a, toc_a, cyc_a};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb_a edge %0d: got %h expected %h", k, a, e);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {active_b, pass_b, fail_b, gto_b, chto_b, first_b, toc_b, cyc_b};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb_b edge %0d: got %h expected %h", k, a, e);
        end
      end
    end
  end

  initial begin
    // 1: kicks every 5 cycles, done at cycle 50 -> PASS
    drive(1, 0, 0, 4'h0, 4'h0);
    settle();
    check("reset_active", active_a, 0);
    check("reset_cycles", cyc_a, 0);
    drive(0, 1, 0, 4'hF, 4'h0);
    for (int c = 1; c <= 50; c++)
      drive(0, 0, c == 50, 4'hF, (c % 5 == 0) ? 4'hF : 4'h0);
    settle();
    check("t1_pass", pass_a, 1);
    check("t1_fail", fail_a, 0);
    check("t1_cycles", cyc_a, 50);
    check("t1_ch_to", chto_a, 0);

    // 2: no channels, no done -> global timeout at 100
    drive(0, 1, 0, 4'h0, 4'h0);
    for (int c = 1; c <= 99; c++) drive(0, 0, 0, 4'h0, 4'h0);
    settle();
    check("t2_active_99", active_a, 1);
    drive(0, 0, 0, 4'h0, 4'h0);
    settle();
    check("t2_fail", fail_a, 1);
    check("t2_global_to", gto_a, 1);
    check("t2_cycles", cyc_a, 100);

    // 3: ch1 kicked, ch2 silent -> FAIL after 8 cycles
    drive(0, 1, 0, 4'b0110, 4'h0);
    for (int c = 1; c <= 8; c++) drive(0, 0, 0, 4'b0110, (c % 3 == 0) ? 4'b0010 : 4'h0);
    settle();
    check("t3_fail", fail_a, 1);
    check("t3_ch_to", chto_a, 4'b0100);
    check("t3_first_ch", first_a, 3'b110);
    check("t3_to_count", toc_a, 1);

    // 4: kick exactly on the expiry cycle, then ch0 and ch3 expire together
    drive(0, 1, 0, 4'b1001, 4'h0);
    for (int c = 1; c <= 8; c++) drive(0, 0, 0, 4'b1001, (c == 8) ? 4'b1001 : 4'h0);
    settle();
    check("t4_no_to", chto_a, 0);
    check("t4_active", active_a, 1);
    for (int c = 9; c <= 16; c++) drive(0, 0, 0, 4'b1001, 4'h0);
    settle();
    check("t4_ch_to", chto_a, 4'b1001);
    check("t4_first_ch", first_a, 3'b100);
    check("t4_to_count", toc_a, 2);

    // 5: non-fatal instance, ch0 never kicked, done at cycle 40
    drive(0, 1, 0, 4'b0001, 4'h0);
    for (int c = 1; c <= 40; c++) drive(0, 0, c == 40, 4'b0001, 4'h0);
    settle();
    check("t5_to_count", toc_b, 5);
    check("t5_ch_to", chto_b, 4'b0001);
    check("t5_pass", pass_b, 1);
    check("t5_cycles", cyc_b, 40);

    // 6: reset mid-run, then restart from FAIL
    drive(0, 1, 0, 4'hF, 4'h0);
    for (int c = 1; c <= 29; c++) drive(0, 0, 0, 4'hF, (c % 5 == 0) ? 4'hF : 4'h0);
    drive(1, 0, 0, 4'hF, 4'h0);
    settle();
    check("t6_rst_active", active_a, 0);
    check("t6_rst_cycles", cyc_a, 0);
    drive(0, 1, 0, 4'h0, 4'h0);
    for (int c = 1; c <= 100; c++) drive(0, 0, 0, 4'h0, 4'h0);
    drive(0, 1, 0, 4'h0, 4'h0);
    settle();
    check("t6_restart_active", active_a, 1);
    check("t6_restart_gto", gto_a, 0);

    // Random traffic, all checked by the scoreboard
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] en, kk;
      en = ($urandom_range(0, 15) == 0) ? 4'($urandom) : ch_en;
      for (int i = 0; i < 4; i++) kk[i] = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 49) == 0, en, kk);
    end
    drive(0, 0, 0, 4'h0, 4'h0);
    settle();
    settle();
    check("queues_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
